// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional even parity,
// one or two stop bits, each bit SB_TICK oversampling ticks long.
module uart_tx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] d_in,
  input  logic            parity,
  input  logic [1:0]      stop_bits,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int unsigned TW = 5;
  localparam int unsigned BW = 3;
  localparam logic [TW-1:0] BIT_END   = TW'(SB_TICK - 1);
  localparam logic [TW-1:0] STOP2_END = TW'(2 * SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [TW-1:0]     tick_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DBIT-1:0]   shreg;
  logic              par_en;
  logic              par_bit;
  logic              two_stop;
  logic [TW-1:0]     stop_end;

  // Both stop bits share one tick count, so two stops end at 2*SB_TICK-1.
  assign stop_end = two_stop ? STOP2_END : BIT_END;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shreg    <= d_in;
            par_en   <= parity;
            par_bit  <= ^d_in;
            two_stop <= stop_bits[1];
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == BIT_END) begin
              tick_cnt <= '0;
              tx       <= shreg[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == BIT_END) begin
              tick_cnt <= '0;
              shreg    <= shreg >> 1;
              bit_cnt  <= bit_cnt + BW'(1);
              if (bit_cnt == LAST_BIT) begin
                if (par_en) begin
                  tx    <= par_bit;
                  state <= PARITY;
                end else begin
                  tx    <= 1'b1;
                  state <= STOP;
                end
              end else begin
                // Next data bit is bit 1 of the pre-shift register.
                tx <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            if (tick_cnt == BIT_END) begin
              tick_cnt <= '0;
              tx       <= 1'b1;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tick_cnt == stop_end) begin
              tick_cnt <= '0;
              tx_done  <= 1'b1;
              tx_busy  <= 1'b0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx: the expected line level is
// derived from the frame bit list and the number of ticks consumed.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       tx_start;
  logic [7:0] d_in;
  logic       parity;
  logic [1:0] stop_bits;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int errors = 0;
  int checks = 0;

  localparam int M_NORM = 0;
  localparam int M_MID  = 1;
  localparam int M_HOLD = 2;
  localparam int M_RST  = 3;

  uart_tx dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .tx_start  (tx_start),
    .d_in      (d_in),
    .parity    (parity),
    .stop_bits (stop_bits),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rand_tick();
    return ($urandom_range(0, 2) == 0);
  endfunction

  // Present a request; returns at the sample point just after the accepting edge.
  task automatic start(input logic [7:0] d, input logic p, input logic [1:0] sb);
    tx_start  = 1'b1;
    d_in      = d;
    parity    = p;
    stop_bits = sb;
    tick      = rand_tick();
    @(negedge clk);
    tx_start  = 1'b0;
  endtask

  // Follow one frame from the sample point after acceptance to the end.
  task automatic follow(input logic [7:0] d, input logic p, input logic [1:0] sb,
                        input int mode, input logic [7:0] nd, input logic np,
                        input logic [1:0] nsb);
    logic       exp_b [0:11];
    logic [7:0] rx;
    int         nb;
    int         n;
    int         k;
    int         cyc;
    bit         inj;
    bit         fin;
    exp_b[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_b[1+i] = d[i];
    nb = 9;
    if (p) begin
      exp_b[nb] = ^d;
      nb++;
    end
    exp_b[nb] = 1'b1;
    nb++;
    if (sb[1]) begin
      exp_b[nb] = 1'b1;
      nb++;
    end
    n   = 16 * nb;
    k   = 0;
    cyc = 0;
    inj = 1'b0;
    fin = 1'b0;
    rx  = '0;
    while (!fin) begin
      if (k < n) begin
        check("tx_bit", 32'(tx), 32'(exp_b[k/16]));
        check("busy_in_frame", 32'(tx_busy), 32'd1);
        check("done_early", 32'(tx_done), 32'd0);
        if (k % 16 == 8 && k / 16 >= 1 && k / 16 <= 8) rx[k/16-1] = tx;
      end else begin
        check("done_pulse", 32'(tx_done), 32'd1);
        check("busy_end", 32'(tx_busy), 32'd0);
        check("tx_gap", 32'(tx), 32'd1);
        fin = 1'b1;
      end
      if (!fin) begin
        if (mode == M_RST && k == 16 * 5 + 4) begin
          reset = 1'b0;
          #1;
          check("rst_tx", 32'(tx), 32'd1);
          check("rst_busy", 32'(tx_busy), 32'd0);
          for (int r = 0; r < 5; r++) begin
            tick = rand_tick();
            @(negedge clk);
            check("rst_hold_tx", 32'(tx), 32'd1);
            check("rst_no_done", 32'(tx_done), 32'd0);
          end
          reset = 1'b1;
          return;
        end
        tx_start  = 1'b0;
        d_in      = 8'($urandom);
        parity    = 1'($urandom);
        stop_bits = 2'($urandom);
        if (mode == M_MID) begin
          d_in = 8'hFF;
          if (k == 80 && !inj) begin
            tx_start = 1'b1;
            inj      = 1'b1;
          end
        end
        if (mode == M_HOLD && k >= n - 20) begin
          tx_start  = 1'b1;
          d_in      = nd;
          parity    = np;
          stop_bits = nsb;
        end
        tick = rand_tick();
        @(negedge clk);
        if (tick) k++;
        cyc++;
        if (cyc > 8000) begin
          check("timeout", 32'd1, 32'd0);
          fin = 1'b1;
        end
      end
    end
    check("rx_byte", 32'(rx), 32'(d));
    tick = rand_tick();
    if (mode == M_HOLD) begin
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check("hold_start_tx", 32'(tx), 32'd0);
      check("hold_start_busy", 32'(tx_busy), 32'd1);
    end else begin
      tx_start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", 32'(tx_done), 32'd0);
      check("idle_after_busy", 32'(tx_busy), 32'd0);
      check("idle_after_tx", 32'(tx), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    logic [1:0] rsb;
    reset     = 1'b0;
    tick      = 1'b0;
    tx_start  = 1'b0;
    d_in      = '0;
    parity    = 1'b0;
    stop_bits = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_done", 32'(tx_done), 32'd0);
    reset = 1'b1;

    // Idle line with ticks and no requests.
    for (int c = 0; c < 2000; c++) begin
      tick = (c % 10 == 0);
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(tx_busy), 32'd0);
      check("idle_done", 32'(tx_done), 32'd0);
    end

    start(8'h55, 1'b0, 2'b01);
    follow(8'h55, 1'b0, 2'b01, M_NORM, 8'h00, 1'b0, 2'b00);
    start(8'h07, 1'b1, 2'b10);
    follow(8'h07, 1'b1, 2'b10, M_NORM, 8'h00, 1'b0, 2'b00);
    start(8'hA3, 1'b1, 2'b01);
    follow(8'hA3, 1'b1, 2'b01, M_NORM, 8'h00, 1'b0, 2'b00);
    start(8'h3C, 1'b0, 2'b00);
    follow(8'h3C, 1'b0, 2'b00, M_MID, 8'h00, 1'b0, 2'b00);
    start(8'h5A, 1'b1, 2'b11);
    follow(8'h5A, 1'b1, 2'b11, M_HOLD, 8'hC6, 1'b1, 2'b01);
    follow(8'hC6, 1'b1, 2'b01, M_NORM, 8'h00, 1'b0, 2'b00);
    start(8'hE4, 1'b0, 2'b01);
    follow(8'hE4, 1'b0, 2'b01, M_RST, 8'h00, 1'b0, 2'b00);
    start(8'h81, 1'b0, 2'b01);
    follow(8'h81, 1'b0, 2'b01, M_NORM, 8'h00, 1'b0, 2'b00);

    for (int f = 0; f < 6; f++) begin
      rd  = 8'($urandom);
      rp  = 1'($urandom);
      rsb = 2'($urandom);
      start(rd, rp, rsb);
      follow(rd, rp, rsb, M_NORM, 8'h00, 1'b0, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
